array_alloc_arbiter: RTL and testbench

- Shared allocator for the array-id resource used by generated test programs: live-id bitmap, high-water counter (`allocs`) and LIFO freed-id stack.
- Arbitrates alloc/free requests from NReq independent instruction sequencers with round-robin priority.
- Returns array ids to the requesters.
- Issues a clear strobe so the owner of the arraySizes table zeroes the affected entry.

---
 rtl/array_alloc_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_array_alloc_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/array_alloc_arbiter.sv
// Shared array-id allocator. Keeps a live-id bitmap, a high-water counter
// (allocs) and a LIFO stack of freed ids, and serves alloc/free requests
// from NReq sequencers one at a time with round-robin priority. Every
// successful operation also strobes sizeClr so the arraySizes owner can
// zero the entry for that id.
module array_alloc_arbiter #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 4,
  parameter int NReq               = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NReq-1:0]                    req,
  input  logic [NReq-1:0]                    op,
  input  logic [NReq*MemoryElementWidth-1:0] freeId,
  output logic [NReq-1:0]                    ack,
  output logic [MemoryElementWidth-1:0]      allocId,
  output logic                               error,
  output logic                               sizeClr,
  output logic [MemoryElementWidth-1:0]      sizeClrId,
  output logic [MemoryElementWidth-1:0]      inUse,
  output logic [MemoryElementWidth-1:0]      allocs
);

  localparam int W    = MemoryElementWidth;
  localparam int IdxW = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int RrW  = (NReq > 1) ? $clog2(NReq) : 1;

  localparam logic [W-1:0]   NArraysW = W'(NArrays);
  localparam logic [W-1:0]   OneW     = W'(1);
  localparam logic [RrW-1:0] LastReq  = RrW'(NReq - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    ACK
  } state_t;

  state_t         state, state_n;
  logic [RrW-1:0] rr, rr_n;
  logic [RrW-1:0] win, win_n;
  logic           cur_op, cur_op_n;
  logic [W-1:0]   cur_id, cur_id_n;
  logic [W-1:0]   res_id, res_id_n;
  logic           fail, fail_n;

  logic [W-1:0]       top, top_n;
  logic [W-1:0]       in_use, in_use_n;
  logic [W-1:0]       alloc_cnt, alloc_cnt_n;
  logic [NArrays-1:0] live, live_n;
  logic [W-1:0]       freed [NArrays];
  logic               push_en;

  logic [NReq-1:0] ack_n;
  logic [W-1:0]    alloc_id_n;
  logic [W-1:0]    size_clr_id_n;
  logic            error_n;
  logic            size_clr_n;

  logic           found;
  logic [RrW-1:0] pick;

  // Round-robin pick: first requester at or above rr, else wrap to the lowest.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NReq; i++) begin
      if (!found && req[i] && (RrW'(i) >= rr)) begin
        found = 1'b1;
        pick  = RrW'(i);
      end
    end
    for (int i = 0; i < NReq; i++) begin
      if (!found && req[i]) begin
        found = 1'b1;
        pick  = RrW'(i);
      end
    end
  end

  // Next-state and datapath: latch the winner, perform the op, then report it.
  always_comb begin
    state_n       = state;
    rr_n          = rr;
    win_n         = win;
    cur_op_n      = cur_op;
    cur_id_n      = cur_id;
    res_id_n      = res_id;
    fail_n        = fail;
    top_n         = top;
    in_use_n      = in_use;
    alloc_cnt_n   = alloc_cnt;
    live_n        = live;
    push_en       = 1'b0;
    ack_n         = '0;
    alloc_id_n    = '0;
    error_n       = 1'b0;
    size_clr_n    = 1'b0;
    size_clr_id_n = '0;

    case (state)
      IDLE: begin
        if (found) begin
          win_n = pick;
          for (int i = 0; i < NReq; i++) begin
            if (RrW'(i) == pick) begin
              cur_op_n = op[i];
              cur_id_n = freeId[i*W +: W];
            end
          end
          state_n = SERVE;
        end
      end

      SERVE: begin
        state_n  = ACK;
        fail_n   = 1'b0;
        res_id_n = '0;
        if (!cur_op) begin
          // Recycled ids take priority over fresh ones.
          if (top != '0) begin
            res_id_n = freed[IdxW'(top - OneW)];
            top_n    = top - OneW;
          end else if (alloc_cnt < NArraysW) begin
            res_id_n    = alloc_cnt;
            alloc_cnt_n = alloc_cnt + OneW;
          end else begin
            fail_n = 1'b1;
          end
          if (!fail_n) begin
            live_n[IdxW'(res_id_n)] = 1'b1;
            in_use_n                = in_use + OneW;
          end
        end else begin
          // Reject ids never handed out and ids that are not currently live.
          if ((cur_id >= alloc_cnt) || !live[IdxW'(cur_id)]) begin
            fail_n = 1'b1;
          end else begin
            live_n[IdxW'(cur_id)] = 1'b0;
            push_en               = 1'b1;
            top_n                 = top + OneW;
            in_use_n              = in_use - OneW;
            res_id_n              = cur_id;
          end
        end
      end

      ACK: begin
        state_n       = IDLE;
        ack_n         = NReq'(1) << win;
        alloc_id_n    = cur_op ? '0 : res_id;
        error_n       = fail;
        size_clr_n    = !fail;
        size_clr_id_n = fail ? '0 : res_id;
        rr_n          = (win == LastReq) ? '0 : win + RrW'(1);
      end

      default: state_n = IDLE;
    endcase
  end

  // State, bookkeeping and registered output pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr        <= '0;
      win       <= '0;
      cur_op    <= 1'b0;
      cur_id    <= '0;
      res_id    <= '0;
      fail      <= 1'b0;
      top       <= '0;
      in_use    <= '0;
      alloc_cnt <= '0;
      live      <= '0;
      ack       <= '0;
      allocId   <= '0;
      error     <= 1'b0;
      sizeClr   <= 1'b0;
      sizeClrId <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      rr        <= rr_n;
      win       <= win_n;
      cur_op    <= cur_op_n;
      cur_id    <= cur_id_n;
      res_id    <= res_id_n;
      fail      <= fail_n;
      top       <= top_n;
      in_use    <= in_use_n;
      alloc_cnt <= alloc_cnt_n;
      live      <= live_n;
      ack       <= ack_n;
      allocId   <= alloc_id_n;
      error     <= error_n;
      sizeClr   <= size_clr_n;
      sizeClrId <= size_clr_id_n;
    end
  end

  // Freed-id stack storage; push writes at the current top.
  always_ff @(posedge clock) begin
    // NOTE: no reset on the stack array; only entries below top are ever read.
    if (push_en) begin
      freed[IdxW'(top)] <= cur_id;
    end
  end

  assign inUse  = in_use;
  assign allocs = alloc_cnt;

endmodule

// File: tb/tb_array_alloc_arbiter.sv
// Self-checking bench for array_alloc_arbiter: directed scenarios followed by
// randomized request rounds, all compared against a queue-based model.
module tb_array_alloc_arbiter;

  localparam int W  = 12;
  localparam int NA = 4;
  localparam int NR = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [NR-1:0]   op;
  logic [NR*W-1:0] freeId;
  logic [NR-1:0]   ack;
  logic [W-1:0]    allocId;
  logic            error;
  logic            sizeClr;
  logic [W-1:0]    sizeClrId;
  logic [W-1:0]    inUse;
  logic [W-1:0]    allocs;

  array_alloc_arbiter #(
    .MemoryElementWidth(W),
    .NArrays           (NA),
    .NReq              (NR)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .op       (op),
    .freeId   (freeId),
    .ack      (ack),
    .allocId  (allocId),
    .error    (error),
    .sizeClr  (sizeClr),
    .sizeClrId(sizeClrId),
    .inUse    (inUse),
    .allocs   (allocs)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: counters, live flags and a LIFO queue of freed ids.
  int m_allocs;
  int m_inuse;
  int m_rr;
  bit m_live [NA];
  int m_freed [$];

  task automatic model_reset();
    m_allocs = 0;
    m_inuse  = 0;
    m_rr     = 0;
    for (int i = 0; i < NA; i++) m_live[i] = 1'b0;
    m_freed.delete();
  endtask

  task automatic model_op(input bit is_free, input int id, output bit fail, output int res);
    fail = 1'b0;
    res  = 0;
    if (!is_free) begin
      if (m_freed.size() > 0) res = m_freed.pop_back();
      else if (m_allocs < NA) begin
        res = m_allocs;
        m_allocs++;
      end else fail = 1'b1;
      if (!fail) begin
        m_live[res] = 1'b1;
        m_inuse++;
      end
    end else begin
      if (id >= m_allocs || !m_live[id]) fail = 1'b1;
      else begin
        m_live[id] = 1'b0;
        m_freed.push_back(id);
        m_inuse--;
        res = id;
      end
    end
  endtask

  function automatic logic [NR*W-1:0] pack3(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'(0));
    check({tag, "_allocId"}, 64'(allocId), 64'(0));
    check({tag, "_error"}, 64'(error), 64'(0));
    check({tag, "_sizeClr"}, 64'(sizeClr), 64'(0));
    check({tag, "_sizeClrId"}, 64'(sizeClrId), 64'(0));
    check({tag, "_inUse"}, 64'(inUse), 64'(0));
    check({tag, "_allocs"}, 64'(allocs), 64'(0));
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    req    = '0;
    op     = '0;
    freeId = '0;
    repeat (2) @(negedge clock);
    check_quiet_outputs("reset");
    reset = 1'b1;
    model_reset();
  endtask

  // Raise all requests in mask together (at a negedge) and follow each ack,
  // dropping the served request as soon as its ack is seen.
  task automatic run_round(input logic [NR-1:0] mask, input logic [NR-1:0] ops,
                           input logic [NR*W-1:0] ids);
    logic [NR-1:0] pending;
    int            w;
    int            waited;
    int            res;
    bit            fail;
    bit            got;
    pending = mask;
    op      = ops;
    freeId  = ids;
    req     = mask;
    while (pending != '0) begin
      w = -1;
      for (int i = 0; i < NR; i++) begin
        if (w < 0 && pending[(m_rr + i) % NR]) w = (m_rr + i) % NR;
      end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 20) begin
        @(negedge clock);
        waited++;
        if (ack != '0) got = 1'b1;
        else check("quiet", 64'({error, sizeClr}), 64'(0));
      end
      if (!got) begin
        check("ack_timeout", 64'(0), 64'(1));
        req = '0;
        return;
      end
      check("latency", 64'(waited), 64'(3));
      model_op(ops[w], int'(W'(ids >> (w * W))), fail, res);
      check("ack", 64'(ack), 64'(NR'(1) << w));
      check("allocId", 64'(allocId), (!ops[w] && !fail) ? 64'(res) : 64'(0));
      check("error", 64'(error), 64'(fail));
      check("sizeClr", 64'(sizeClr), 64'(!fail));
      if (!fail) check("sizeClrId", 64'(sizeClrId), 64'(res));
      check("inUse", 64'(inUse), 64'(m_inuse));
      check("allocs", 64'(allocs), 64'(m_allocs));
      pending[w] = 1'b0;
      req[w]     = 1'b0;
      m_rr       = (w + 1) % NR;
    end
  endtask

  task automatic single(input bit is_free, input int id);
    run_round(3'b001, {2'b00, is_free}, pack3(id, 0, 0));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NR-1:0] mask;
    logic [NR-1:0] ops;

    do_reset();

    // Single requester: alloc/free of id 0, three times.
    for (int k = 0; k < 3; k++) begin
      single(1'b0, 0);
      single(1'b1, 0);
    end

    // Round robin: three allocs in order r0,r1,r2, then r0 gets the last id.
    do_reset();
    run_round(3'b111, 3'b000, pack3(0, 0, 0));
    run_round(3'b111, 3'b000, pack3(0, 0, 0));

    // Illegal frees: id beyond allocs, then double free.
    do_reset();
    single(1'b0, 0);
    single(1'b1, 3);
    single(1'b1, 0);
    single(1'b1, 0);

    // LIFO reuse and exhaustion.
    do_reset();
    run_round(3'b111, 3'b000, pack3(0, 0, 0));
    single(1'b1, 1);
    single(1'b1, 2);
    single(1'b0, 0);
    single(1'b0, 0);
    single(1'b0, 0);
    single(1'b0, 0);
    single(1'b1, 1);
    single(1'b0, 0);

    // Reset during SERVE of an alloc: no ack, everything back to zero.
    @(negedge clock);
    req    = 3'b001;
    op     = 3'b000;
    freeId = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    #1 check_quiet_outputs("midop");
    req = '0;
    repeat (2) begin
      @(negedge clock);
      check("midop_noack", 64'(ack), 64'(0));
    end
    reset = 1'b1;
    model_reset();
    single(1'b0, 0);

    // Randomized rounds.
    for (int k = 0; k < 150; k++) begin
      mask = NR'($urandom_range(1, 7));
      ops  = NR'($urandom_range(0, 7));
      run_round(mask, ops, pack3($urandom_range(0, 5), $urandom_range(0, 5),
                                 $urandom_range(0, 5)));
    end

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
